// File: rtl/fast_segment_test.sv
`default_nettype none
// ============================================================================
//  Module   : fast_segment_test
//  Purpose  : FAST-9 segment test for one candidate pixel per job. Fetches
//             the 16 Bresenham-circle samples over a request/valid handshake,
//             classifies each one as bright/dark against the centre pixel and
//             threshold, scans the circle (with wrap-around) for a contiguous
//             arc of ARC_LEN samples, and reports a corner flag and score.
//  Ports    : clk, n_rst           - clock, asynchronous active-low reset
//             fast_start           - level enable; a job launches while high
//             threshold/center_pix - t and c, latched at job launch
//             ring_req/ring_idx    - circle-sample request and index
//             ring_pix/ring_valid  - returned sample and its qualifier
//             fast_done_flag       - one-cycle pulse per evaluated pixel
//             corner_flag/score    - result, held until the next report
//             col_idx              - column of the pixel just reported
//  Options  : FAST_EARLY_REJECT_EN - fetch compass points 0,4,8,12 first and
//             finish early when fewer than two are bright and fewer than two
//             are dark (no arc of 9 or more can then exist).
//  Revision : 1.0 - initial release
// ============================================================================
module fast_segment_test #(
    parameter int WIDTH   = 400,
    parameter int ARC_LEN = 9,
    parameter int PIX_W   = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     fast_start,
    input  logic [PIX_W-1:0]         threshold,
    input  logic [PIX_W-1:0]         center_pix,
    output logic                     ring_req,
    output logic [3:0]               ring_idx,
    input  logic [PIX_W-1:0]         ring_pix,
    input  logic                     ring_valid,
    output logic                     fast_done_flag,
    output logic                     corner_flag,
    output logic [PIX_W+3:0]         corner_score,
    output logic [$clog2(WIDTH)-1:0] col_idx
);

    localparam int          C_COL_W     = $clog2(WIDTH);
    localparam logic [4:0]  C_ARC       = 5'(ARC_LEN);
    localparam logic [4:0]  C_RUN_MAX   = 5'd16;
    localparam logic [4:0]  C_EVAL_LAST = 5'(14 + ARC_LEN);
    localparam logic [C_COL_W-1:0] C_COL_LAST = C_COL_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Position in the fetch sequence -> circle index.
`ifdef FAST_EARLY_REJECT_EN
    function automatic logic [3:0] f_order(input logic [3:0] pos);
        logic [3:0] m;
        if (pos < 4'd4) begin
            f_order = {pos[1:0], 2'b00};
        end else begin
            // Remaining non-compass indices, ascending: skip every 4th.
            m       = pos - 4'd4;
            f_order = m + (m / 4'd3) + 4'd1;
        end
    endfunction
`else
    function automatic logic [3:0] f_order(input logic [3:0] pos);
        f_order = pos;
    endfunction
`endif

    state_t               r_state;
    logic [PIX_W-1:0]     r_c;
    logic [PIX_W-1:0]     r_t;
    logic [15:0]          r_bmask;
    logic [15:0]          r_dmask;
    logic [PIX_W+3:0]     r_sum_b;
    logic [PIX_W+3:0]     r_sum_d;
    logic [3:0]           r_load_cnt;
    logic [4:0]           r_pos;
    logic [4:0]           r_run_b;
    logic [4:0]           r_run_d;
    logic                 r_found_b;
    logic                 r_found_d;
    logic [C_COL_W-1:0]   r_col_cnt;

    // One extra bit so c+t and p+t never overflow.
    logic [PIX_W:0] w_p;
    logic [PIX_W:0] w_c;
    logic [PIX_W:0] w_t;
    logic           w_bright;
    logic           w_dark;
    logic [PIX_W:0] w_diff_b;
    logic [PIX_W:0] w_diff_d;
    logic           w_bit_b;
    logic           w_bit_d;
    logic [4:0]     w_run_b_nxt;
    logic [4:0]     w_run_d_nxt;
    logic           w_launch;

    assign w_p      = {1'b0, ring_pix};
    assign w_c      = {1'b0, r_c};
    assign w_t      = {1'b0, r_t};
    assign w_bright = w_p > (w_c + w_t);
    assign w_dark   = (w_p + w_t) < w_c;
    assign w_diff_b = w_p - w_c - w_t;
    assign w_diff_d = w_c - w_p - w_t;

    // r_pos[3:0] is k mod 16, so the scan wraps 15 -> 0 for free.
    assign w_bit_b     = r_bmask[r_pos[3:0]];
    assign w_bit_d     = r_dmask[r_pos[3:0]];
    assign w_run_b_nxt = !w_bit_b ? 5'd0 : ((r_run_b == C_RUN_MAX) ? C_RUN_MAX : r_run_b + 5'd1);
    assign w_run_d_nxt = !w_bit_d ? 5'd0 : ((r_run_d == C_RUN_MAX) ? C_RUN_MAX : r_run_d + 5'd1);

    // A job starts from IDLE, or back-to-back straight out of DONE.
    assign w_launch = fast_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

`ifdef FAST_EARLY_REJECT_EN
    // Compass tallies at the 4th compass accept (index 12 is on the bus).
    logic [2:0] w_cb;
    logic [2:0] w_cd;
    assign w_cb = {2'b0, r_bmask[0]} + {2'b0, r_bmask[4]} + {2'b0, r_bmask[8]} + {2'b0, w_bright};
    assign w_cd = {2'b0, r_dmask[0]} + {2'b0, r_dmask[4]} + {2'b0, r_dmask[8]} + {2'b0, w_dark};
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state        <= ST_IDLE;
            r_c            <= '0;
            r_t            <= '0;
            r_bmask        <= '0;
            r_dmask        <= '0;
            r_sum_b        <= '0;
            r_sum_d        <= '0;
            r_load_cnt     <= '0;
            r_pos          <= '0;
            r_run_b        <= '0;
            r_run_d        <= '0;
            r_found_b      <= 1'b0;
            r_found_d      <= 1'b0;
            r_col_cnt      <= '0;
            ring_req       <= 1'b0;
            ring_idx       <= '0;
            fast_done_flag <= 1'b0;
            corner_flag    <= 1'b0;
            corner_score   <= '0;
            col_idx        <= '0;
        end else begin
            fast_done_flag <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                end
                ST_LOAD: begin
                    if (ring_valid) begin
                        if (w_bright) begin
                            r_bmask[ring_idx] <= 1'b1;
                            r_sum_b           <= r_sum_b + {3'b000, w_diff_b};
                        end
                        if (w_dark) begin
                            r_dmask[ring_idx] <= 1'b1;
                            r_sum_d           <= r_sum_d + {3'b000, w_diff_d};
                        end
                        if (r_load_cnt == 4'd15) begin
                            ring_req <= 1'b0;
                            r_pos    <= '0;
                            r_state  <= ST_EVAL;
                        end
`ifdef FAST_EARLY_REJECT_EN
                        else if ((r_load_cnt == 4'd3) && (w_cb < 3'd2) && (w_cd < 3'd2)) begin
                            // found_b/found_d stay clear, so DONE reports 0/0.
                            ring_req <= 1'b0;
                            r_state  <= ST_DONE;
                        end
`endif
                        else begin
                            r_load_cnt <= r_load_cnt + 4'd1;
                            ring_idx   <= f_order(r_load_cnt + 4'd1);
                        end
                    end
                end
                ST_EVAL: begin
                    r_run_b <= w_run_b_nxt;
                    r_run_d <= w_run_d_nxt;
                    if (w_run_b_nxt >= C_ARC) r_found_b <= 1'b1;
                    if (w_run_d_nxt >= C_ARC) r_found_d <= 1'b1;
                    if (r_pos == C_EVAL_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_pos <= r_pos + 5'd1;
                    end
                end
                ST_DONE: begin
                    fast_done_flag <= 1'b1;
                    corner_flag    <= r_found_b | r_found_d;
                    // Bright and dark arcs of >= 9 cannot coexist on 16 points.
                    corner_score   <= r_found_b ? r_sum_b : (r_found_d ? r_sum_d : '0);
                    col_idx        <= r_col_cnt;
                    r_col_cnt      <= (r_col_cnt == C_COL_LAST) ? '0 : r_col_cnt + 1'b1;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Launch overrides the IDLE/DONE next-state choice above.
            if (w_launch) begin
                r_state    <= ST_LOAD;
                r_c        <= center_pix;
                r_t        <= threshold;
                r_bmask    <= '0;
                r_dmask    <= '0;
                r_sum_b    <= '0;
                r_sum_d    <= '0;
                r_load_cnt <= '0;
                r_run_b    <= '0;
                r_run_d    <= '0;
                r_found_b  <= 1'b0;
                r_found_d  <= 1'b0;
                ring_req   <= 1'b1;
                ring_idx   <= f_order(4'd0);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fast_segment_test.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fast_segment_test
//  Purpose  : Scoreboard bench for fast_segment_test. Jobs are queued with
//             their expected result (from a direct circle-arc model); a ring
//             responder serves samples with a configurable wait; a monitor
//             checks every done pulse against the scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fast_segment_test;

    localparam int WIDTH   = 400;
    localparam int ARC_LEN = 9;
    localparam int PIX_W   = 8;

    logic        clk        = 1'b0;
    logic        n_rst      = 1'b0;
    logic        fast_start = 1'b0;
    logic [7:0]  threshold  = '0;
    logic [7:0]  center_pix = '0;
    logic        ring_req;
    logic [3:0]  ring_idx;
    logic [7:0]  ring_pix   = '0;
    logic        ring_valid = 1'b0;
    logic        fast_done_flag;
    logic        corner_flag;
    logic [11:0] corner_score;
    logic [8:0]  col_idx;

    fast_segment_test #(.WIDTH(WIDTH), .ARC_LEN(ARC_LEN), .PIX_W(PIX_W)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .fast_start     (fast_start),
        .threshold      (threshold),
        .center_pix     (center_pix),
        .ring_req       (ring_req),
        .ring_idx       (ring_idx),
        .ring_pix       (ring_pix),
        .ring_valid     (ring_valid),
        .fast_done_flag (fast_done_flag),
        .corner_flag    (corner_flag),
        .corner_score   (corner_score),
        .col_idx        (col_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic flag;
        int   score;
        int   col;
        int   lat;
    } exp_t;

    int           errors   = 0;
    int           checks   = 0;
    int           dly      = 0;
    int           exp_col  = 0;
    int           launches = 0;
    int           done_cnt = 0;
    exp_t         exp_q[$];
    int           launch_q[$];
    logic [127:0] samp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int exp_order(input int k);
`ifdef FAST_EARLY_REJECT_EN
        int ord[16] = '{0, 4, 8, 12, 1, 2, 3, 5, 6, 7, 9, 10, 11, 13, 14, 15};
        return ord[k];
`else
        return k;
`endif
    endfunction

    // Reference: classify each point, longest circular run, sums over all.
    function automatic exp_t model(input int c, input int t, input logic [127:0] s, input int d);
        exp_t e;
        int   p;
        int   b[16];
        int   k[16];
        int   sb = 0;
        int   sd = 0;
        int   best_b = 0;
        int   best_d = 0;
        for (int i = 0; i < 16; i++) begin
            p    = int'(s[i*8 +: 8]);
            b[i] = (p > c + t) ? 1 : 0;
            k[i] = (p + t < c) ? 1 : 0;
            if (b[i] == 1) sb += p - c - t;
            if (k[i] == 1) sd += c - p - t;
        end
        for (int st = 0; st < 16; st++) begin
            int rb = 0;
            int rd = 0;
            while (rb < 16 && b[(st + rb) % 16] == 1) rb++;
            while (rd < 16 && k[(st + rd) % 16] == 1) rd++;
            if (rb > best_b) best_b = rb;
            if (rd > best_d) best_d = rd;
        end
        e.flag  = (best_b >= ARC_LEN) || (best_d >= ARC_LEN);
        e.score = (best_b >= ARC_LEN) ? sb : ((best_d >= ARC_LEN) ? sd : 0);
        e.lat   = 16 * (d + 1) + 15 + ARC_LEN + 1;
`ifdef FAST_EARLY_REJECT_EN
        if ((b[0] + b[4] + b[8] + b[12] < 2) && (k[0] + k[4] + k[8] + k[12] < 2))
            e.lat = 4 * (d + 1) + 1;
`endif
        e.col = 0;
        return e;
    endfunction

    // Ring responder: serves samples after dly wait cycles; logs accepts.
    initial begin
        logic [127:0] cur = '0;
        int  wcnt = 0, acc_cnt = 0, first_idx = 0, drive_idx = 0;
        bit  drove = 0, req_prev = 0;
        forever begin
            @(negedge clk);
            if (drove) begin
                if (acc_cnt < 16) chk("ring_order", drive_idx, exp_order(acc_cnt));
                else              chk("ring_accept_count", acc_cnt, 15);
                acc_cnt++;
            end
            drove = 0;
            if (!ring_req) begin
                ring_valid = 1'b0;
                wcnt       = 0;
                req_prev   = 0;
            end else begin
                if (!req_prev) begin
                    if (samp_q.size() > 0) cur = samp_q.pop_front();
                    else begin
                        cur = '0;
                        chk("samples_queued", 0, 1);
                    end
                    acc_cnt = 0;
                    launch_q.push_back(cyc);
                    launches++;
                end
                req_prev = 1;
                if (wcnt == 0) first_idx = int'(ring_idx);
                if (wcnt >= dly) begin
                    if (dly > 0) chk("ring_idx_stable", ring_idx, first_idx);
                    ring_valid = 1'b1;
                    ring_pix   = cur[int'(ring_idx)*8 +: 8];
                    drive_idx  = int'(ring_idx);
                    drove      = 1;
                    wcnt       = 0;
                end else begin
                    ring_valid = 1'b0;
                    wcnt++;
                end
            end
        end
    end

    // Result monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (fast_done_flag) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("corner_flag", corner_flag, e.flag);
                    chk("corner_score", corner_score, e.score);
                    chk("col_idx", col_idx, e.col);
                    if (launch_q.size() > 0) chk("latency", cyc - launch_q.pop_front(), e.lat);
                    else                     chk("launch_seen", 0, 1);
                end
            end
        end
    end

    function automatic logic [127:0] fill(input int v);
        logic [127:0] s;
        for (int i = 0; i < 16; i++) s[i*8 +: 8] = 8'(v);
        return s;
    endfunction

    function automatic logic [127:0] arc(input int base, input int v, input int st, input int len);
        logic [127:0] s;
        s = fill(base);
        for (int i = 0; i < len; i++) s[((st + i) % 16)*8 +: 8] = 8'(v);
        return s;
    endfunction

    function automatic logic [127:0] rand_ring(input int c, input int t);
        logic [127:0] s;
        int mode, len, st, v;
        mode = int'($urandom_range(0, 2));
        for (int i = 0; i < 16; i++) s[i*8 +: 8] = 8'($urandom_range(0, 255));
        if (mode > 0) begin
            len = int'($urandom_range(6, 16));
            st  = int'($urandom_range(0, 15));
            for (int i = 0; i < len; i++) begin
                if (mode == 1) v = c + t + 1 + int'($urandom_range(0, 40));
                else           v = c - t - 1 - int'($urandom_range(0, 40));
                if (v > 255) v = 255;
                if (v < 0)   v = 0;
                s[((st + i) % 16)*8 +: 8] = 8'(v);
            end
        end
        return s;
    endfunction

    task automatic queue_job(input int c, input int t, input logic [127:0] s);
        exp_t e;
        e     = model(c, t, s, dly);
        e.col = exp_col;
        exp_col = (exp_col + 1) % WIDTH;
        exp_q.push_back(e);
        samp_q.push_back(s);
        center_pix = 8'(c);
        threshold  = 8'(t);
    endtask

    task automatic wait_launch();
        int  prev = launches;
        bit  seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (launches != prev) seen = 1;
        end
        if (!seen) chk("launch_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) chk("done_timeout", exp_q.size(), 0);
    endtask

    task automatic idle_job(input int c, input int t, input logic [127:0] s);
        @(negedge clk);
        queue_job(c, t, s);
        fast_start = 1'b1;
        wait_launch();
        fast_start = 1'b0;
        wait_drain();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_done"},   fast_done_flag, 0);
        chk({tag, "_corner"}, corner_flag, 0);
        chk({tag, "_score"},  corner_score, 0);
        chk({tag, "_col"},    col_idx, 0);
        chk({tag, "_req"},    ring_req, 0);
    endtask

    initial begin
        int c, t, prev;
        repeat (3) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        n_rst = 1'b1;

        // Zero-wait directed cases, then random.
        dly = 0;
        idle_job(100, 20, fill(200));
        idle_job(100, 20, arc(100, 150, 12, 9));
        idle_job(100, 20, arc(100, 150, 12, 8));
        idle_job(100, 20, fill(120));
        idle_job(100, 20, fill(79));
        for (int j = 0; j < 8; j++) begin
            c = int'($urandom_range(0, 255));
            t = int'($urandom_range(0, 60));
            idle_job(c, t, rand_ring(c, t));
        end

        // Three wait cycles per sample.
        dly = 3;
        idle_job(100, 20, arc(100, 150, 12, 9));
        for (int j = 0; j < 3; j++) begin
            c = int'($urandom_range(0, 255));
            t = int'($urandom_range(0, 60));
            idle_job(c, t, rand_ring(c, t));
        end
        idle_job(100, 20, fill(200));

        // Reset in the middle of EVAL: outputs clear, no done pulse.
        dly = 0;
        @(negedge clk);
        queue_job(100, 20, fill(200));
        fast_start = 1'b1;
        wait_launch();
        fast_start = 1'b0;
        repeat (20) @(negedge clk);
        prev  = done_cnt;
        n_rst = 1'b0;
        #1;
        check_zero_outputs("midjob_reset");
        repeat (3) @(negedge clk);
        chk("no_done_after_reset", done_cnt, prev);
        exp_q.delete();
        launch_q.delete();
        samp_q.delete();
        exp_col = 0;
        n_rst   = 1'b1;
        repeat (2) @(negedge clk);

        // WIDTH+1 back-to-back jobs, fast_start dropped during the last LOAD.
        @(negedge clk);
        c = int'($urandom_range(0, 255));
        t = int'($urandom_range(0, 60));
        queue_job(c, t, rand_ring(c, t));
        fast_start = 1'b1;
        for (int j = 0; j <= WIDTH; j++) begin
            wait_launch();
            if (j < WIDTH) begin
                c = int'($urandom_range(0, 255));
                t = int'($urandom_range(0, 60));
                queue_job(c, t, rand_ring(c, t));
            end
        end
        repeat (5) @(negedge clk);
        fast_start = 1'b0;
        wait_drain();
        prev = launches;
        repeat (60) @(negedge clk);
        chk("idle_no_relaunch", launches, prev);
        chk("idle_req_low", ring_req, 0);
        chk("idle_col_wrapped", col_idx, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fast_segment_test.md
Name: fast_segment_test

Overview:
- Per-pixel FAST-9 segment-test engine.
- Consumed by the FAST controller: evaluates one candidate pixel per job while `fast_start` is high, and pulses `fast_done_flag` once per pixel so the controller can count columns.
- Fetches the 16 Bresenham-circle samples from the Gaussian window buffer through a request/valid handshake.
- Outputs a corner flag and a score for the downstream NMS/orientation stage.

Parameters:
- WIDTH, 400, image columns; range of `col_idx`.
- ARC_LEN, 9, minimum contiguous arc length; legal range 9..16.
- PIX_W, 8, pixel bit width.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- fast_start  in  1  level enable from the controller; a new job launches only while high
- threshold  in  PIX_W  intensity threshold t, sampled at job launch
- center_pix  in  PIX_W  candidate pixel c, sampled at job launch
- ring_req  out  1  circle-sample request
- ring_idx  out  4  requested circle index 0..15
- ring_pix  in  PIX_W  returned circle sample
- ring_valid  in  1  ring_pix valid for the current ring_idx
- fast_done_flag  out  1  one-cycle pulse per evaluated pixel
- corner_flag  out  1  corner result; valid with fast_done_flag
- corner_score  out  PIX_W+4  score; valid with fast_done_flag
- col_idx  out  clog2(WIDTH)  column of the pixel just reported

Behaviour:
- Reset values: all outputs 0, state IDLE, col_idx 0, accumulators 0.
- States:
  - IDLE: if fast_start, latch c and t, clear masks and accumulators, go to LOAD.
  - LOAD: drive ring_req=1 with ring_idx = current index.
    - A sample is accepted in any cycle with ring_valid=1; a same-cycle combinational valid is legal.
    - After an accept the index advances next cycle. ring_req stays high and ring_idx stays stable until accepted.
    - After index 15 is accepted, go to EVAL.
  - EVAL: serial scan over 15+ARC_LEN positions k, one per cycle, using index k mod 16 so the arc wraps across 15→0.
    - Keep separate bright and dark run counters, 5 bits, saturating at 16.
    - A counter increments when its bit is set and resets to 0 when clear.
    - found_b / found_d are set when the respective run reaches ARC_LEN or more.
    - After the last position, go to DONE.
  - DONE: for one cycle, fast_done_flag=1, corner_flag = found_b OR found_d, and corner_score is set.
    - corner_score = bright sum if found_b, dark sum if found_d, else 0. Both cannot be set, since ARC_LEN≥9.
    - Output col_idx, then col_idx increments, wrapping WIDTH-1→0.
    - Next state is LOAD if fast_start is high (relaunch, latching new c and t), else IDLE.
  - corner_flag and corner_score hold their values until the next DONE.
- Classification uses PIX_W+1-bit arithmetic, with no overflow:
  - bright if p > c+t; dark if p+t < c.
  - Equality is neither bright nor dark.
- Score accumulation during LOAD:
  - Bright sum += p−c−t for bright samples.
  - Dark sum += c−p−t for dark samples.
  - Maximum 16·255 = 4080 fits in PIX_W+4 bits.
- Latency with zero-wait valid: launch→done = 16 (LOAD) + 15+ARC_LEN (EVAL) + 1 = 41 cycles at ARC_LEN=9.
- If fast_start deasserts mid-job, the current pixel completes and reports; then the block returns to IDLE.
- If n_rst asserts mid-job, the block immediately returns to reset values, with no done pulse.

Optional Feature:
- Macro: FAST_EARLY_REJECT_EN.
- Enabled:
  - LOAD fetches the compass indices 0,4,8,12 first, then the remaining 12 in ascending order.
  - After the 4th compass accept, if fewer than 2 are bright AND fewer than 2 are dark, skip the remaining loads and EVAL and go directly to DONE with corner_flag=0, score=0.
  - This is valid because any arc of ≥9 covers ≥2 compass points.
  - Reject latency is 4+1 = 5 cycles.
- Disabled: fixed ascending fetch order 0..15; no early exit.
- corner_flag results are identical either way.

Test Plan:
1. c=100, t=20, all 16 samples=200, zero-wait valid → done pulse 41 cycles after launch, corner_flag=1, corner_score=16·80=1280, col_idx=0.
2. Bright arc on indices 12..15,0..4 (9 samples = 150), others 100; c=100, t=20 → corner_flag=1 (wrap arc), score=9·30=270.
3. Same as 2 but only 8 contiguous bright samples (12..15,0..3) → corner_flag=0, score=0; with FAST_EARLY_REJECT_EN, reject pulse arrives at cycle 5 only if compass counts are below 2.
4. Boundary: c=100, t=20, all samples=120 (equality) → corner_flag=0; all samples=79 → dark corner, score=16·1=16.
5. ring_valid delayed 3 cycles per sample → ring_req and ring_idx are held stable while waiting, the accepted order is correct, done arrives at 16·4+24+1 cycles, and the result matches zero-wait.
6. fast_start held for WIDTH+1 jobs → col_idx sequence 0..399 then 0. Deassert fast_start mid-LOAD → the job completes, then the block goes IDLE. Assert n_rst mid-EVAL → no done pulse and all outputs 0.
